// File: rtl/sma_engine.sv
// sma_engine: short and long simple moving averages over an 8-bit sample stream.
// Optional build macro SMA_ROUND_EN selects round-half-up averages instead of truncation.
module sma_engine #(
    parameter int SHORT_LEN = 4,
    parameter int LONG_LEN  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       flush,
    output logic [7:0] current_data,
    output logic [7:0] short_sma,
    output logic [7:0] long_sma,
    output logic       sma_strobe,
    output logic       sma_valid
);

    localparam int SK = $clog2(SHORT_LEN);
    localparam int LK = $clog2(LONG_LEN);
    localparam int SW = 8 + SK;
    localparam int LW = 8 + LK;
    localparam logic [LK-1:0] SHORT_OFS = LK'(SHORT_LEN);
    localparam logic [LK:0]   FULL      = (LK+1)'(LONG_LEN);

    // Handshake: data_in is taken on every rising edge with data_valid high and
    // flush low; there is no ready. Each taken sample yields exactly one
    // sma_strobe cycle one edge later, and outputs hold between strobes.

    logic [7:0]    hist [LONG_LEN];
    logic [LK-1:0] wr_ptr;
    logic [LK:0]   fill_cnt;
    logic [SW-1:0] short_sum;
    logic [LW-1:0] long_sum;

    logic [7:0]    old_long;
    logic [7:0]    old_short;
    logic [SW-1:0] short_next;
    logic [LW-1:0] long_next;
    logic [LK:0]   fill_next;
    logic [7:0]    short_avg;
    logic [7:0]    long_avg;

    // Evicted terms are already inside their sums, so the modular subtract is exact.
    always_comb begin
        old_long   = hist[wr_ptr];
        old_short  = hist[wr_ptr - SHORT_OFS];
        long_next  = long_sum + LW'(data_in) - LW'(old_long);
        short_next = short_sum + SW'(data_in) - SW'(old_short);
        fill_next  = (fill_cnt == FULL) ? fill_cnt : fill_cnt + (LK+1)'(1);
    end

`ifdef SMA_ROUND_EN
    localparam logic [SW:0] S_HALF = (SW+1)'(1) << (SK - 1);
    localparam logic [LW:0] L_HALF = (LW+1)'(1) << (LK - 1);
    // One extra bit keeps a full-scale sum plus the half step from wrapping.
    assign short_avg = 8'(({1'b0, short_next} + S_HALF) >> SK);
    assign long_avg  = 8'(({1'b0, long_next} + L_HALF) >> LK);
`else
    assign short_avg = 8'(short_next >> SK);
    assign long_avg  = 8'(long_next >> LK);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LONG_LEN; i++) hist[i] <= '0;
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            short_sum    <= '0;
            long_sum     <= '0;
            current_data <= '0;
            short_sma    <= '0;
            long_sma     <= '0;
            sma_strobe   <= 1'b0;
            sma_valid    <= 1'b0;
        end else if (flush) begin
            // Flush beats a coincident sample, which is dropped.
            for (int i = 0; i < LONG_LEN; i++) hist[i] <= '0;
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            short_sum    <= '0;
            long_sum     <= '0;
            current_data <= '0;
            short_sma    <= '0;
            long_sma     <= '0;
            sma_strobe   <= 1'b0;
            sma_valid    <= 1'b0;
        end else if (data_valid) begin
            hist[wr_ptr] <= data_in;
            wr_ptr       <= wr_ptr + LK'(1);
            fill_cnt     <= fill_next;
            short_sum    <= short_next;
            long_sum     <= long_next;
            current_data <= data_in;
            short_sma    <= short_avg;
            long_sma     <= long_avg;
            sma_strobe   <= 1'b1;
            sma_valid    <= (fill_next == FULL);
        end else begin
            sma_strobe   <= 1'b0;
        end
    end

endmodule
